// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - receiver state type and default divisor shared by the uart_rx_fifo files
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // 100 MHz / 57600 baud / 16 oversampling
    localparam logic [15:0] CLKDIV_DEFAULT = 16'd108;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - synchronous FIFO storage with pointers and occupancy count
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && o_valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_valid ? r_mem[r_rptr] : '0;
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver feeding a byte FIFO
// UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter logic [15:0] CLKDIV_RESET = CLKDIV_DEFAULT,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        srx_pad_i,
    input  logic [15:0]                 clkdiv_i,
    output logic [7:0]                  dat_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        framing_err_o,
    output logic                        overrun_o,
    output logic                        parity_err_o
);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t DATA_NEXT = ST_PARITY;
`else
    localparam rx_state_t DATA_NEXT = ST_STOP;
`endif

    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_div;
    logic [15:0] r_tick_cnt;
    rx_state_t   r_state;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  r_nbits;
    logic [7:0]  r_shift;
    logic        r_framing_err;
    logic        r_overrun;
    logic        w_rx;
    logic        w_tick;
    logic        w_stop_tick;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_par_drop;

    assign w_rx        = r_sync2;
    // >= rather than == so a divisor lowered while idle cannot strand the counter
    assign w_tick      = (r_tick_cnt >= r_div);
    assign w_stop_tick = w_tick && (r_state == ST_STOP) && (r_bit_cnt == 4'd7);
    assign w_push      = w_stop_tick && w_rx && !w_par_drop;
    assign w_pop       = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_div      <= CLKDIV_RESET;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= srx_pad_i;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
            if (r_state == ST_IDLE) begin
                r_div <= clkdiv_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_nbits   <= '0;
            r_shift   <= '0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        r_nbits   <= '0;
                        r_state   <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_nbits <= r_nbits + 4'd1;
                    end
                    if (r_bit_cnt == 4'd15 && r_nbits == 4'd8) begin
                        r_state <= DATA_NEXT;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // leave mid stop bit so a back-to-back start edge is not missed
                    if (r_bit_cnt == 4'd7) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_tick;
    logic w_par_mismatch;

    assign w_par_tick     = w_tick && (r_state == ST_PARITY) && (r_bit_cnt == 4'd7);
    assign w_par_mismatch = ^{r_shift, w_rx};
    assign w_par_drop     = r_par_bad;
    assign parity_err_o   = r_parity_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_tick && w_par_mismatch;
            if (w_par_tick) begin
                r_par_bad <= w_par_mismatch;
            end else if (w_tick && r_state == ST_START) begin
                r_par_bad <= 1'b0;
            end
        end
    end
`else
    assign w_par_drop   = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= w_stop_tick && !w_rx;
            r_overrun     <= w_push && w_full && !w_pop;
        end
    end

    assign framing_err_o = r_framing_err;
    assign overrun_o     = r_overrun;

    uart_rx_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_mem (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (ready_i),
        .o_data  (dat_o),
        .o_valid (valid_o),
        .o_full  (w_full),
        .o_count (count_o)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with serial driver and byte-queue model
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int          DEPTH    = 16;
    localparam logic [15:0] DIV      = 16'd4;
    localparam int          BIT_CLKS = 16 * (DIV + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        srx;
    logic        ready;
    logic [15:0] clkdiv;
    logic [7:0]  dat;
    logic        valid;
    logic [4:0]  count;
    logic        fe;
    logic        ovr;
    logic        pe;

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_fe = 0, n_ovr = 0, n_pe = 0;
    int exp_fe = 0, exp_ovr = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKDIV_RESET(16'd108), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .srx_pad_i(srx), .clkdiv_i(clkdiv),
        .dat_o(dat), .valid_o(valid), .ready_i(ready), .count_o(count),
        .framing_err_o(fe), .overrun_o(ovr), .parity_err_o(pe)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: a good frame lands in the FIFO unless it is already full, in which case it is an overrun.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit mess_div);
        if (!stop_ok) exp_fe++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr++;
        srx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            if (mess_div && i == 3) clkdiv = 16'd9;
            step(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        srx = ^b;
        step(BIT_CLKS);
`endif
        clkdiv = DIV;
        if (stop_ok) begin
            srx = 1'b1;
            step(BIT_CLKS);
        end else begin
            srx = 1'b0;
            step(BIT_CLKS / 4);
            srx = 1'b1;
            step(BIT_CLKS - BIT_CLKS / 4);
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) step(1);
        chk({nm, "_drained"}, exp_q.size(), 0);
        step(2);
        chk({nm, "_count_zero"}, count, 0);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fe) n_fe++;
            if (ovr) n_ovr++;
            if (pe) n_pe++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %02h, required no byte", dat);
                end else begin
                    chk("pop_data", dat, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] b81;
        bit         ok;

        rst = 1'b1; srx = 1'b1; ready = 1'b0; clkdiv = DIV;
        step(4);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        chk("rst_dat", dat, 0);
        chk("rst_pulses", {fe, ovr, pe}, 0);
        rst = 1'b0;
        step(BIT_CLKS);

        send_byte(8'hA5, 1'b1, 1'b0);
        step(2);
        chk("a5_count", count, 1);
        chk("a5_valid", valid, 1);
        chk("a5_dat", dat, 8'hA5);
        chk("a5_no_err", n_fe + n_ovr + n_pe, 0);
        ready = 1'b1;
        wait_drain("a5");

        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        wait_drain("b2b");

        ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(2);
        chk("full_count", count, exp_q.size());
        chk("full_count_limit", count, DEPTH);
        chk("overrun_pulses", n_ovr, exp_ovr);
        ready = 1'b1;
        wait_drain("full");

        send_byte(8'h3C, 1'b0, 1'b0);
        step(BIT_CLKS);
        chk("frame_count", count, 0);
        chk("frame_pulses", n_fe, exp_fe);

        srx = 1'b0;
        step(3 * (DIV + 1));
        srx = 1'b1;
        step(2 * BIT_CLKS);
        chk("glitch_count", count, 0);
        chk("glitch_err", n_fe + n_ovr + n_pe, exp_fe + exp_ovr);

        send_byte(8'h96, 1'b1, 1'b1);
        wait_drain("divchg");

        ready = 1'b0;
        send_byte(8'h11, 1'b1, 1'b0);
        step(2);
        chk("pre_rst_count", count, exp_q.size());
        b81 = 8'h81;
        srx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            srx = b81[i];
            step(BIT_CLKS);
        end
        srx = b81[4];
        step(BIT_CLKS / 2);
        rst = 1'b1;
        srx = 1'b1;
        step(3);
        chk("midrst_valid", valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_pulses", {fe, ovr, pe}, 0);
        exp_q.delete();
        rst = 1'b0;
        step(2 * BIT_CLKS);
        chk("post_rst_count", count, 0);
        ready = 1'b1;
        send_byte(8'h7E, 1'b1, 1'b0);
        wait_drain("post_rst");

        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_byte(b, ok, 1'b0);
            step($urandom_range(0, 40));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        wait_drain("random");

        chk("total_framing", n_fe, exp_fe);
        chk("total_overrun", n_ovr, exp_ovr);
        chk("total_parity", n_pe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKDIV_RESET, default 16'd108, reset value of the 16x-tick divisor (100 MHz / 57600 / 16).
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; SHALL be a power of two, 2..256.
REQ-003 Port clk_i  input  1  sole clock; all logic on posedge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port srx_pad_i  input  1  serial line, idle high; driven by the serial BFM's stx_pad_o.
REQ-006 Port clkdiv_i  input  16  run-time divisor; sampled only while rx state is IDLE.
REQ-007 Port dat_o  output  8  head-of-FIFO byte.
REQ-008 Port valid_o  output  1  FIFO non-empty.
REQ-009 Port ready_i  input  1  consumer accept; a pop occurs when valid_o && ready_i.
REQ-010 Port count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 Port framing_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-012 Port overrun_o  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-013 Port parity_err_o  output  1  one-cycle pulse on parity mismatch (tied 0 without UART_RX_PARITY_EN).

Function
REQ-014 Tick: counter increments each clk_i; when equal to divisor it clears and asserts tick for one cycle (period = divisor+1 clocks).
REQ-015 srx_pad_i SHALL pass a 2-flop synchronizer before use; flop reset value 1.
REQ-016 States IDLE, START, DATA, PARITY, STOP; transitions only on tick; bit counter 0..15 per bit.
REQ-017 IDLE: synchronized line 0 on tick -> START, bit counter 0; divisor latched from clkdiv_i.
REQ-018 START: at counter 7 line still 0 -> counter 0, enter DATA; line 1 -> IDLE (glitch, no error).
REQ-019 DATA: sample at counter 7, 8 bits LSB first into shift register; after 8th bit, at counter 15 -> PARITY if enabled else STOP.
REQ-020 STOP: sample at counter 7; 1 -> push byte, 0 -> framing_err_o pulse, byte dropped; either way -> IDLE on that tick (half stop bit, allows back-to-back frames).
REQ-021 Push with FIFO full and no same-cycle pop: byte dropped, overrun_o pulse, contents unchanged.
REQ-022 Push and pop in same cycle SHALL both occur, including when full (count unchanged).
REQ-023 Pop when empty SHALL have no effect; dat_o is don't-care while valid_o=0.
REQ-024 Latency: pushed byte visible on dat_o/valid_o the cycle after the push cycle.
REQ-025 Pointers wrap modulo FIFO_DEPTH; count_o never exceeds FIFO_DEPTH.
REQ-026 Divisor change mid-frame SHALL not affect the frame in progress.

Reset
REQ-027 While rst_i=1: state IDLE, counters 0, FIFO empty, valid_o=0, count_o=0, dat_o=0, all error pulses 0, divisor=CLKDIV_RESET.
REQ-028 Reset mid-frame SHALL discard the partial byte and all FIFO contents; no error pulse.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit at counter 7; mismatch -> parity_err_o pulse and byte dropped, then -> STOP.
REQ-030 Macro undefined: PARITY state, parity logic absent; parity_err_o tied 0; frame is 8N1.

Structure
REQ-031 Package uart_rx_pkg holds the state enum typedef and the default-divisor constant.
REQ-032 Sub-module uart_rx_fifo_mem (synchronous FIFO storage, pointers, count) instantiated once.

Verification
REQ-033 Divisor 4, send 0xA5 8N1 -> dat_o=0xA5, valid_o=1, count_o=1, no error pulses.
REQ-034 Send 0x00,0xFF,0x55 back-to-back, ready_i=1 -> three pops in order, count_o returns 0.
REQ-035 ready_i=0, send FIFO_DEPTH+1 bytes -> count_o=FIFO_DEPTH, exactly one overrun_o pulse, first FIFO_DEPTH bytes intact.
REQ-036 Send 0x3C with stop bit 0 -> framing_err_o single pulse, count_o stays 0.
REQ-037 Low glitch of 3 tick periods on idle line -> no push, no error, state back to IDLE.
REQ-038 Assert rst_i during DATA bit 4 of 0x81 -> FIFO empty; next frame 0x7E received correctly.
